// File: rtl/bgd_dot_accum_if.sv
// Operand-in and result-out streams of the BGD dot-product accumulator.
// slave is the accumulator's view of the bus and master is the driver's view.
interface bgd_dot_accum_if #(
    parameter int DATA_W = 13,
    parameter int ACC_W  = 24
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic signed [ACC_W-1:0]  out_acc;
    logic                     out_sat;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_acc, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_acc, out_sat
    );
endinterface

// File: rtl/bgd_dot_accum.sv
// Sequences operand pairs into an external pipelined multiplier and accumulates
// the returning products over a programmed length, then hands out a saturated sum.
module bgd_dot_accum #(
    parameter int DATA_W  = 13,
    parameter int ACC_W   = 24,
    parameter int LEN_W   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    bgd_dot_accum_if.slave           bus,
    output logic                     mul_ce,
    output logic signed [DATA_W-1:0] mul_din0,
    output logic signed [DATA_W-1:0] mul_din1,
    input  logic signed [DATA_W-1:0] mul_dout,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN = -SAT_MAX - ACC_W'(1);
    localparam logic signed [DATA_W-1:0] SAT_HI  = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_LO  = {1'b1, {(DATA_W - 1){1'b0}}};

    state_t                   state;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         count;
    logic [LEN_W-1:0]         count_next;
    logic [MUL_LAT-1:0]       vpipe;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  product_ext;
    logic                     issue;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic signed [ACC_W-1:0]  out_acc_q;
    logic                     out_sat_q;
    logic signed [DATA_W-1:0] sat_data;
    logic                     sat_flag;

    assign issue       = bus.in_valid & in_ready_q;
    assign count_next  = count + LEN_W'(1);
    assign product_ext = {{(ACC_W - DATA_W){mul_dout[DATA_W-1]}}, mul_dout};

    assign mul_din0      = bus.in_a;
    assign mul_din1      = bus.in_b;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;

    always_comb begin
        sat_flag = 1'b0;
        sat_data = acc[DATA_W-1:0];
        if (acc > SAT_MAX) begin
            sat_flag = 1'b1;
            sat_data = SAT_HI;
        end else if (acc < SAT_MIN) begin
            sat_flag = 1'b1;
            sat_data = SAT_LO;
        end
    end

    // vpipe follows each multiplier slot so only real issues are ever summed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            len_q       <= '0;
            count       <= '0;
            vpipe       <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b0;
            mul_ce      <= 1'b0;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (mul_ce) begin
                vpipe <= {vpipe[MUL_LAT-2:0], issue};
                if (vpipe[MUL_LAT-1]) begin
                    acc <= acc + product_ext;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        if (len == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= '0;
                            out_acc_q   <= '0;
                            out_sat_q   <= 1'b0;
                        end else begin
                            state      <= ACCUM;
                            in_ready_q <= 1'b1;
                            mul_ce     <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (issue) begin
                        count <= count_next;
                        if (count_next == len_q) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (vpipe == '0) begin
                        state       <= DONE;
                        mul_ce      <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= sat_data;
                        out_acc_q   <= acc;
                        out_sat_q   <= sat_flag;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bgd_dot_accum.sv
// Self-checking bench for bgd_dot_accum with a 3-stage truncating multiplier model
// and a scoreboard of expected results released on each output handshake.
module tb_bgd_dot_accum;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        len;
    logic              mul_ce;
    logic signed [12:0] mul_din0;
    logic signed [12:0] mul_din1;
    logic signed [12:0] mul_dout;
    logic              busy;

    logic signed [12:0] m0 = '0;
    logic signed [12:0] m1 = '0;
    logic signed [12:0] m2 = '0;
    int                ce_count = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          len;
        int          first;
        logic [31:0] pattern;
        int          hold;
        int          exp_acc;
        int          exp_data;
        int          exp_sat;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int acc;
        int data;
        int sat;
    } exp_t;

    int   pa[32];
    int   pb[32];
    vec_t vecs[8];
    exp_t sbq[$];

    bgd_dot_accum_if bus ();

    bgd_dot_accum dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .bus      (bus),
        .mul_ce   (mul_ce),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // The multiplier is deliberately never reset so stale products linger across aborts.
    always @(posedge clk) begin
        if (mul_ce) begin
            m0 <= mul_din0 * mul_din1;
            m1 <= m0;
            m2 <= m1;
        end
    end
    assign mul_dout = m2;

    always @(posedge clk) begin
        if (mul_ce) ce_count <= ce_count + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int   issued;
        int   p;
        int   guard;
        int   lat;
        int   ce_before;
        logic rdy;
        exp_t e;

        e.acc  = v.exp_acc;
        e.data = v.exp_data;
        e.sat  = v.exp_sat;
        sbq.push_back(e);
        ce_before = ce_count;

        start = 1'b1;
        len   = 8'(v.len);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);

        issued = 0;
        p      = 0;
        guard  = 0;
        while (issued < v.len && guard < 64) begin
            bus.in_valid = (p < 32) ? v.pattern[p] : 1'b1;
            bus.in_a     = 13'(pa[v.first + issued]);
            bus.in_b     = 13'(pb[v.first + issued]);
            rdy          = bus.in_ready;
            @(posedge clk);
            if (bus.in_valid && rdy) issued++;
            #1;
            p++;
            guard++;
        end
        bus.in_valid = 1'b0;
        checkOutput("issued_count", issued, v.len);

        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("out_valid_rise", int'(bus.out_valid), 1);
        checkOutput("result_latency", lat, v.exp_lat);
        if (v.len == 0) checkOutput("len0_no_mul_ce", ce_count - ce_before, 0);

        for (int h = 0; h < v.hold; h++) begin
            checkOutput("hold_valid", int'(bus.out_valid), 1);
            checkOutput("hold_data", int'(bus.out_data), v.exp_data);
            checkOutput("hold_acc", int'(bus.out_acc), v.exp_acc);
            @(posedge clk);
            #1;
        end

        bus.out_ready = 1'b1;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                checkOutput("sb_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                checkOutput("out_data", int'(bus.out_data), e.data);
                checkOutput("out_acc", int'(bus.out_acc), e.acc);
                checkOutput("out_sat", int'(bus.out_sat), e.sat);
            end
        end else begin
            checkOutput("handshake_seen", 0, 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("out_valid_drop", int'(bus.out_valid), 0);
        checkOutput("busy_idle", int'(busy), 0);
    endtask

    initial begin
        vec_t r;

        pa[0]  = 1;    pb[0]  = 5;
        pa[1]  = 2;    pb[1]  = 6;
        pa[2]  = 3;    pb[2]  = 7;
        pa[3]  = 4;    pb[3]  = 8;
        pa[4]  = 100;  pb[4]  = 100;
        for (int i = 5; i < 9; i++) begin pa[i] = 60; pb[i] = 60; end
        pa[9]  = -60;  pb[9]  = 60;
        pa[10] = -60;  pb[10] = 60;
        pa[11] = -3;   pb[11] = 7;
        pa[12] = 5;    pb[12] = -2;
        pa[13] = 12;   pb[13] = 11;
        pa[14] = -8;   pb[14] = -9;
        pa[15] = 100;  pb[15] = -1;
        pa[16] = 0;    pb[16] = 50;
        pa[17] = 7;    pb[17] = 7;
        pa[18] = -1;   pb[18] = -1;
        pa[19] = -100; pb[19] = 100;
        pa[20] = 10;   pb[20] = -3;
        pa[21] = -7;   pb[21] = -7;
        pa[22] = 25;   pb[22] = 4;
        pa[23] = 3;    pb[23] = 3;
        pa[24] = 4;    pb[24] = 4;
        for (int i = 25; i < 32; i++) begin pa[i] = 9 + i; pb[i] = 11; end

        vecs[0] = '{4, 0,  32'hFFFF_FFFF, 0, 70,    70,    0, 4};
        vecs[1] = '{1, 4,  32'hFFFF_FFFF, 0, 1808,  1808,  0, 4};
        vecs[2] = '{4, 5,  32'hFFFF_FFFF, 0, 14400, 4095,  1, 4};
        vecs[3] = '{2, 9,  32'hFFFF_FFFF, 0, -7200, -4096, 1, 4};
        vecs[4] = '{0, 0,  32'hFFFF_FFFF, 0, 0,     0,     0, 0};
        vecs[5] = '{8, 11, 32'hFFFF_FFFF, 2, 123,   123,   0, 4};
        vecs[6] = '{1, 19, 32'hFFFF_FFFF, 0, -1808, -1808, 0, 4};
        vecs[7] = '{3, 20, 32'hFFFF_FFE9, 5, 119,   119,   0, 4};

        reset         = 1'b1;
        start         = 1'b0;
        len           = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_in_ready", int'(bus.in_ready), 0);
        checkOutput("rst_mul_ce", int'(mul_ce), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_out_data", int'(bus.out_data), 0);
        checkOutput("rst_out_acc", int'(bus.out_acc), 0);
        checkOutput("rst_out_sat", int'(bus.out_sat), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d len=%0d", i, vecs[i].len);
            applyStimulus(vecs[i]);
        end

        $display("[TB] abort mid-accumulation then recover");
        start = 1'b1;
        len   = 8'd4;
        @(posedge clk);
        #1;
        start        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = 13'(pa[25]);
        bus.in_b     = 13'(pb[25]);
        @(posedge clk);
        #1;
        bus.in_a = 13'(pa[26]);
        bus.in_b = 13'(pb[26]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("pre_abort_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_out_valid", int'(bus.out_valid), 0);
        checkOutput("abort_in_ready", int'(bus.in_ready), 0);
        checkOutput("abort_mul_ce", int'(mul_ce), 0);
        checkOutput("abort_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        r = '{2, 23, 32'hFFFF_FFFF, 0, 25, 25, 0, 4};
        applyStimulus(r);

        checkOutput("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
